// File: rtl/rng_pkg.sv
// Shared types and constants for the TRNG stream run controller.
package rng_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } rng_state_t;

  localparam int RNG_WORD_BYTES = 4;
  localparam int RNG_BYTE_MASK  = ~3;

endpackage

// File: rtl/rng_out_slot.sv
// Single-entry output register feeding the AXI4-Stream master port.
// A load overwrites the entry; the top only loads when empty or draining.
module rng_out_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_last,
  input  logic        ready,
  output logic [31:0] tdata,
  output logic        tvalid,
  output logic        tlast,
  output logic        full
);

  logic [31:0] data_reg;
  logic        last_reg;
  logic        valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      last_reg  <= load_last;
      valid_reg <= 1'b1;
    end else if (valid_reg && ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign tdata  = data_reg;
  assign tlast  = last_reg;
  assign tvalid = valid_reg;
  assign full   = valid_reg;

endmodule

// File: rtl/rng_stream_ctrl.sv
// Run controller between the TRNG word generator and the DMA stream port.
// Define RNG_SUM_EN to build the RNG_SUM_DATA accumulator; otherwise it reads 0.
module rng_stream_ctrl
  import rng_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             RNG_GO,
  input  logic             RNG_STOP,
  input  logic [CNT_W-1:0] RNG_SEND_BYTES,
  input  logic [CNT_W-1:0] RNG_DMA_BYTES,
  input  logic [31:0]      RND_DATA,
  input  logic             RND_VALID,
  output logic [31:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic             M_AXIS_TLAST,
  output logic             RNG_RUN,
  output logic             RNG_OVER,
  output logic [CNT_W-1:0] RNG_SENT_BYTES,
  output logic [31:0]      RNG_SUM_DATA
);

  localparam logic [CNT_W-1:0] BYTE_MASK  = CNT_W'(RNG_BYTE_MASK);
  localparam logic [CNT_W-1:0] WORD_BYTES = CNT_W'(RNG_WORD_BYTES);

  rng_state_t       state_reg;
  logic             run_reg;
  logic             over_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [CNT_W-1:0] pkt_reg;
  logic [CNT_W-1:0] sent_reg;
  logic [CNT_W-1:0] bud_reg;
  logic [CNT_W-1:0] pl_reg;

  logic             full;
  logic             active;
  logic             hs;
  logic             accept;
  logic             overrun;
  logic             go_start;
  logic             final_word;
  logic             pkt_done;
  logic             word_last;
  logic             full_next;
  logic [CNT_W-1:0] acc_inc;
  logic [CNT_W-1:0] pkt_next;
  logic [CNT_W-1:0] dma_masked;

  assign active     = (state_reg == RUN) || (state_reg == FLUSH);
  assign hs         = full && M_AXIS_TREADY;
  assign accept     = active && RND_VALID && (!full || hs);
  assign overrun    = active && RND_VALID && full && !hs;
  assign go_start   = (state_reg == IDLE) && RNG_GO && !RNG_STOP;
  assign acc_inc    = acc_reg + WORD_BYTES;
  assign final_word = (bud_reg != '0) && (acc_inc == bud_reg);
  // Extra bit keeps the packet-length compare honest near the top of the range.
  assign pkt_done   = ({1'b0, pkt_reg} + {1'b0, WORD_BYTES}) >= {1'b0, pl_reg};
  assign word_last  = pkt_done || final_word || (state_reg == FLUSH);
  assign pkt_next   = !accept ? pkt_reg : (word_last ? '0 : pkt_reg + WORD_BYTES);
  assign full_next  = accept || (full && !hs);
  assign dma_masked = RNG_DMA_BYTES & BYTE_MASK;

  rng_out_slot u_slot (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (accept),
    .load_data (RND_DATA),
    .load_last (word_last),
    .ready     (M_AXIS_TREADY),
    .tdata     (M_AXIS_TDATA),
    .tvalid    (M_AXIS_TVALID),
    .tlast     (M_AXIS_TLAST),
    .full      (full)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_reg <= IDLE;
      run_reg   <= 1'b0;
      over_reg  <= 1'b0;
      acc_reg   <= '0;
      pkt_reg   <= '0;
      sent_reg  <= '0;
      bud_reg   <= '0;
      pl_reg    <= '0;
    end else begin
      if (hs)      sent_reg <= sent_reg + WORD_BYTES;
      if (accept) begin
        acc_reg <= acc_inc;
        pkt_reg <= pkt_next;
      end
      if (overrun) over_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (go_start) begin
            state_reg <= RUN;
            run_reg   <= 1'b1;
            over_reg  <= 1'b0;
            acc_reg   <= '0;
            pkt_reg   <= '0;
            sent_reg  <= '0;
            bud_reg   <= RNG_SEND_BYTES & BYTE_MASK;
            pl_reg    <= (dma_masked == '0) ? WORD_BYTES : dma_masked;
          end
        end
        RUN: begin
          // STOP looks at the packet fill after this cycle's accept, if any.
          if (accept && final_word) begin
            state_reg <= DRAIN;
          end else if (RNG_STOP) begin
            if (pkt_next != '0) begin
              state_reg <= FLUSH;
            end else if (full_next) begin
              state_reg <= DRAIN;
            end else begin
              state_reg <= IDLE;
              run_reg   <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (accept) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!full || hs) begin
            state_reg <= IDLE;
            run_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          run_reg   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RNG_SUM_EN
  logic [31:0] sum_reg;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sum_reg <= '0;
    end else if (go_start) begin
      sum_reg <= '0;
    end else if (hs) begin
      sum_reg <= sum_reg + M_AXIS_TDATA;
    end
  end

  assign RNG_SUM_DATA = sum_reg;
`else
  assign RNG_SUM_DATA = 32'd0;
`endif

  assign RNG_RUN        = run_reg;
  assign RNG_OVER       = over_reg;
  assign RNG_SENT_BYTES = sent_reg;

endmodule

// File: tb/tb_rng_stream_ctrl.sv
// Directed bench for rng_stream_ctrl: a vector table for two short runs,
// then hand-written sequences for backpressure, stop, reset and the sum.
module tb_rng_stream_ctrl;

`ifdef RNG_SUM_EN
  localparam bit SUM_ON = 1'b1;
`else
  localparam bit SUM_ON = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        RNG_GO;
  logic        RNG_STOP;
  logic [31:0] RNG_SEND_BYTES;
  logic [31:0] RNG_DMA_BYTES;
  logic [31:0] RND_DATA;
  logic        RND_VALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY;
  logic        M_AXIS_TLAST;
  logic        RNG_RUN;
  logic        RNG_OVER;
  logic [31:0] RNG_SENT_BYTES;
  logic [31:0] RNG_SUM_DATA;

  int n_vec = 0;
  int n_bad = 0;

  rng_stream_ctrl #(.CNT_W(32)) dut (
    .ACLK           (ACLK),
    .ARESET         (ARESET),
    .RNG_GO         (RNG_GO),
    .RNG_STOP       (RNG_STOP),
    .RNG_SEND_BYTES (RNG_SEND_BYTES),
    .RNG_DMA_BYTES  (RNG_DMA_BYTES),
    .RND_DATA       (RND_DATA),
    .RND_VALID      (RND_VALID),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .RNG_RUN        (RNG_RUN),
    .RNG_OVER       (RNG_OVER),
    .RNG_SENT_BYTES (RNG_SENT_BYTES),
    .RNG_SUM_DATA   (RNG_SUM_DATA)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        go, stop, valid, tready;
    logic [31:0] data, send, dma;
    logic        e_tvalid;
    logic [31:0] e_tdata;
    logic        e_tlast, e_run, e_over;
    logic [31:0] e_sent, e_sum;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %h", nm, act);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply(input logic go, input logic stop, input logic valid,
                       input logic [31:0] data, input logic tready);
    RNG_GO = go; RNG_STOP = stop; RND_VALID = valid; RND_DATA = data;
    M_AXIS_TREADY = tready;
    @(posedge ACLK); #1;
    RNG_GO = 1'b0; RNG_STOP = 1'b0;
  endtask

  function automatic logic [31:0] sum_exp(input logic [31:0] s);
    return SUM_ON ? s : 32'd0;
  endfunction

  initial begin
    ARESET = 1'b1; RNG_GO = 1'b0; RNG_STOP = 1'b0; RND_VALID = 1'b0;
    RND_DATA = '0; M_AXIS_TREADY = 1'b1;
    RNG_SEND_BYTES = '0; RNG_DMA_BYTES = '0;

    // go stop vld rdy data send dma | tvalid tdata tlast run over sent sum
    tbl[0]  = '{1,0,0,1, 32'h000, 16, 8, 0, 32'h000, 0, 1, 0,  0, 32'h000};
    tbl[1]  = '{0,0,1,1, 32'h101, 16, 8, 1, 32'h101, 0, 1, 0,  0, 32'h000};
    tbl[2]  = '{0,0,1,1, 32'h102, 16, 8, 1, 32'h102, 1, 1, 0,  4, 32'h101};
    tbl[3]  = '{0,0,1,1, 32'h103, 16, 8, 1, 32'h103, 0, 1, 0,  8, 32'h203};
    tbl[4]  = '{0,0,1,1, 32'h104, 16, 8, 1, 32'h104, 1, 1, 0, 12, 32'h306};
    tbl[5]  = '{0,0,1,1, 32'h105, 16, 8, 0, 32'h000, 0, 0, 0, 16, 32'h40A};
    tbl[6]  = '{0,0,1,1, 32'h106, 16, 8, 0, 32'h000, 0, 0, 0, 16, 32'h40A};
    tbl[7]  = '{1,0,0,1, 32'h000, 10, 0, 0, 32'h000, 0, 1, 0,  0, 32'h000};
    tbl[8]  = '{0,0,1,1, 32'h201, 10, 0, 1, 32'h201, 1, 1, 0,  0, 32'h000};
    tbl[9]  = '{0,0,1,1, 32'h202, 10, 0, 1, 32'h202, 1, 1, 0,  4, 32'h201};
    tbl[10] = '{0,0,0,1, 32'h000, 10, 0, 0, 32'h000, 0, 0, 0,  8, 32'h403};
    tbl[11] = '{0,0,1,1, 32'h203, 10, 0, 0, 32'h000, 0, 0, 0,  8, 32'h403};

    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    chk("reset tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("reset tlast",  {31'd0, M_AXIS_TLAST},  32'd0);
    chk("reset tdata",  M_AXIS_TDATA, 32'd0);
    chk("reset run",    {31'd0, RNG_RUN},  32'd0);
    chk("reset over",   {31'd0, RNG_OVER}, 32'd0);
    chk("reset sent",   RNG_SENT_BYTES, 32'd0);
    chk("reset sum",    RNG_SUM_DATA, 32'd0);

    for (int i = 0; i < 12; i++) begin
      RNG_SEND_BYTES = tbl[i].send;
      RNG_DMA_BYTES  = tbl[i].dma;
      apply(tbl[i].go, tbl[i].stop, tbl[i].valid, tbl[i].data, tbl[i].tready);
      chk($sformatf("v%0d tvalid", i), {31'd0, M_AXIS_TVALID}, {31'd0, tbl[i].e_tvalid});
      if (tbl[i].e_tvalid) begin
        chk($sformatf("v%0d tdata", i), M_AXIS_TDATA, tbl[i].e_tdata);
        chk($sformatf("v%0d tlast", i), {31'd0, M_AXIS_TLAST}, {31'd0, tbl[i].e_tlast});
      end
      chk($sformatf("v%0d run", i),  {31'd0, RNG_RUN},  {31'd0, tbl[i].e_run});
      chk($sformatf("v%0d over", i), {31'd0, RNG_OVER}, {31'd0, tbl[i].e_over});
      chk($sformatf("v%0d sent", i), RNG_SENT_BYTES, tbl[i].e_sent);
      chk($sformatf("v%0d sum", i),  RNG_SUM_DATA, sum_exp(tbl[i].e_sum));
    end

    // Backpressure with overrun, then STOP mid-packet flushes one word.
    RNG_SEND_BYTES = 0; RNG_DMA_BYTES = 16;
    apply(1, 0, 0, 32'h0, 1);
    chk("bp run", {31'd0, RNG_RUN}, 32'd1);
    apply(0, 0, 1, 32'hC1, 1);
    chk("bp first tdata", M_AXIS_TDATA, 32'hC1);
    chk("bp first over", {31'd0, RNG_OVER}, 32'd0);
    apply(0, 0, 1, 32'hC2, 0);
    chk("bp hold1 tdata", M_AXIS_TDATA, 32'hC1);
    chk("bp hold1 over", {31'd0, RNG_OVER}, 32'd1);
    apply(0, 0, 1, 32'hC3, 0);
    chk("bp hold2 tdata", M_AXIS_TDATA, 32'hC1);
    apply(0, 0, 1, 32'hC4, 0);
    chk("bp hold3 tdata", M_AXIS_TDATA, 32'hC1);
    chk("bp hold3 tvalid", {31'd0, M_AXIS_TVALID}, 32'd1);
    apply(0, 0, 1, 32'hC5, 1);
    chk("bp reload tdata", M_AXIS_TDATA, 32'hC5);
    chk("bp reload tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
    chk("bp reload sent", RNG_SENT_BYTES, 32'd4);
    apply(0, 1, 0, 32'h0, 1);
    chk("bp stop tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("bp stop run", {31'd0, RNG_RUN}, 32'd1);
    apply(0, 0, 1, 32'hC6, 1);
    chk("bp flush tdata", M_AXIS_TDATA, 32'hC6);
    chk("bp flush tlast", {31'd0, M_AXIS_TLAST}, 32'd1);
    apply(0, 0, 0, 32'h0, 1);
    chk("bp end run", {31'd0, RNG_RUN}, 32'd0);
    chk("bp end sent", RNG_SENT_BYTES, 32'd12);
    chk("bp end over", {31'd0, RNG_OVER}, 32'd1);
    apply(0, 0, 0, 32'h0, 1);
    chk("bp idle over", {31'd0, RNG_OVER}, 32'd1);
    apply(1, 0, 0, 32'h0, 1);
    chk("bp rego over", {31'd0, RNG_OVER}, 32'd0);
    chk("bp rego sent", RNG_SENT_BYTES, 32'd0);
    apply(0, 1, 0, 32'h0, 1);
    chk("bp empty stop run", {31'd0, RNG_RUN}, 32'd0);

    // GO and STOP together in IDLE do nothing.
    apply(1, 1, 0, 32'h0, 1);
    chk("go+stop run", {31'd0, RNG_RUN}, 32'd0);

    // STOP after two handshaken words: FLUSH emits exactly one TLAST word.
    apply(1, 0, 0, 32'h0, 1);
    apply(0, 0, 1, 32'hD1, 1);
    apply(0, 0, 1, 32'hD2, 1);
    chk("sm2 tdata", M_AXIS_TDATA, 32'hD2);
    apply(0, 0, 0, 32'h0, 1);
    chk("sm2 sent", RNG_SENT_BYTES, 32'd8);
    apply(0, 1, 0, 32'h0, 1);
    chk("sm2 flush run", {31'd0, RNG_RUN}, 32'd1);
    apply(0, 0, 1, 32'hD3, 1);
    chk("sm2 flush tdata", M_AXIS_TDATA, 32'hD3);
    chk("sm2 flush tlast", {31'd0, M_AXIS_TLAST}, 32'd1);
    apply(0, 0, 0, 32'h0, 1);
    chk("sm2 end run", {31'd0, RNG_RUN}, 32'd0);
    chk("sm2 end sent", RNG_SENT_BYTES, 32'd12);
    apply(0, 0, 1, 32'hD4, 1);
    chk("sm2 idle tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);

    // STOP on a packet boundary: straight to IDLE, no extra word.
    apply(1, 0, 0, 32'h0, 1);
    apply(0, 0, 1, 32'hE1, 1);
    apply(0, 0, 1, 32'hE2, 1);
    apply(0, 0, 1, 32'hE3, 1);
    chk("sm4 w3 tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
    apply(0, 0, 1, 32'hE4, 1);
    chk("sm4 w4 tdata", M_AXIS_TDATA, 32'hE4);
    chk("sm4 w4 tlast", {31'd0, M_AXIS_TLAST}, 32'd1);
    apply(0, 0, 0, 32'h0, 1);
    chk("sm4 drained sent", RNG_SENT_BYTES, 32'd16);
    apply(0, 1, 0, 32'h0, 1);
    chk("sm4 stop run", {31'd0, RNG_RUN}, 32'd0);
    apply(0, 0, 1, 32'hE5, 1);
    chk("sm4 idle tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);

    // Asynchronous reset while a word is on the bus.
    RNG_SEND_BYTES = 16; RNG_DMA_BYTES = 8;
    apply(1, 0, 0, 32'h0, 1);
    apply(0, 0, 1, 32'hF1, 1);
    apply(0, 0, 1, 32'hF2, 1);
    chk("rst pre sent", RNG_SENT_BYTES, 32'd4);
    #2 ARESET = 1'b1;
    #1;
    chk("rst tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    chk("rst run", {31'd0, RNG_RUN}, 32'd0);
    chk("rst sent", RNG_SENT_BYTES, 32'd0);
    RND_VALID = 1'b0;
    @(posedge ACLK); #1 ARESET = 1'b0;

    // Clean restart plus sum wraparound.
    RNG_SEND_BYTES = 8; RNG_DMA_BYTES = 0;
    apply(1, 0, 0, 32'h0, 1);
    chk("sum run", {31'd0, RNG_RUN}, 32'd1);
    chk("sum start sent", RNG_SENT_BYTES, 32'd0);
    apply(0, 0, 1, 32'hFFFF_FFFF, 1);
    chk("sum w1 tdata", M_AXIS_TDATA, 32'hFFFF_FFFF);
    apply(0, 0, 1, 32'h0000_0002, 1);
    chk("sum w2 tlast", {31'd0, M_AXIS_TLAST}, 32'd1);
    apply(0, 0, 0, 32'h0, 1);
    chk("sum end run", {31'd0, RNG_RUN}, 32'd0);
    chk("sum end sent", RNG_SENT_BYTES, 32'd8);
    chk("sum value", RNG_SUM_DATA, sum_exp(32'h0000_0001));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rng_stream_ctrl.md
Name: rng_stream_ctrl

Overview:
- Run controller between the TRNG word generator and the AXI4-Stream DMA port.
- Sequences one run from GO/STOP, meters a byte budget, and cuts the stream into DMA packets by driving TLAST.
- Buffers one word, flags overrun when the entropy source outruns the DMA, and reports SENT_BYTES/SUM_DATA status to the register block.

Parameters:
- CNT_W, 32, width of byte counters and of SEND_BYTES/DMA_BYTES/SENT_BYTES (min 8).

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset, asynchronous, active-high.
- RNG_GO  in  1  one-cycle start pulse.
- RNG_STOP  in  1  one-cycle stop pulse.
- RNG_SEND_BYTES  in  CNT_W  run byte budget; 0 = unlimited.
- RNG_DMA_BYTES  in  CNT_W  packet length in bytes.
- RND_DATA  in  32  generator word.
- RND_VALID  in  1  generator word valid. No backpressure exists.
- M_AXIS_TDATA  out  32  stream data.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TREADY  in  1  stream ready.
- M_AXIS_TLAST  out  1  packet end.
- RNG_RUN  out  1  run active.
- RNG_OVER  out  1  sticky overrun.
- RNG_SENT_BYTES  out  CNT_W  bytes handshaken this run.
- RNG_SUM_DATA  out  32  mod-2^32 sum of words handshaken.

Behaviour:
- Reset (async, ARESET=1): state IDLE; all outputs 0; slot empty; all counters 0.
- Budget and packet length:
  - Effective budget BUD = SEND_BYTES & ~3. BUD=0 means unlimited.
  - Effective packet length PL = DMA_BYTES & ~3; PL=0 is treated as 4.
  - Both are sampled into internal registers at GO.
- Word acceptance:
  - A word is accepted when RND_VALID=1, state is RUN or FLUSH, and the slot is empty or being handshaken in the same cycle.
  - An accepted word appears on TDATA with TVALID=1 on the next cycle (latency 1).
  - TDATA/TLAST are held stable while TVALID=1 and TREADY=0.
- Overrun: RND_VALID=1 in RUN/FLUSH while the slot is full and not draining:
  - the word is dropped and RNG_OVER <= 1;
  - RNG_OVER stays set until the next GO.
- Counters:
  - ACC (accepted bytes) and PKT (bytes in current packet) increase by 4 per accepted word.
  - SENT_BYTES increases by 4 per TVALID&TREADY handshake.
  - SUM_DATA += TDATA per handshake.
  - All counters wrap modulo their width.
- TLAST rule: set on an accepted word if PKT+4 >= PL, or the word is final (ACC+4 == BUD, or the FLUSH word).
  - PKT clears to 0 when a TLAST word is accepted.
- State machine (RNG_RUN=1 in every state except IDLE):
  - IDLE: GO -> RUN. ACC, PKT, SENT_BYTES, SUM_DATA and OVER are cleared. STOP is ignored.
  - RUN:
    - final budget word accepted -> DRAIN.
    - STOP with PKT==0 -> DRAIN if slot full, else IDLE.
    - STOP with PKT!=0 -> FLUSH.
    - GO is ignored.
  - FLUSH: next accepted word gets TLAST -> DRAIN. GO/STOP are ignored.
  - DRAIN: accepts no new words. Slot handshaken -> IDLE. GO/STOP are ignored.
- Simultaneous events:
  - GO and STOP in the same cycle: STOP wins (in IDLE, nothing happens).
  - Accept and handshake in the same cycle: the slot reloads with no bubble.
- Reset mid-operation discards the slot with no TLAST emitted; the DMA side is reset by the same ARESET.

Optional Feature:
- Macro: RNG_SUM_EN.
- Defined: RNG_SUM_DATA accumulator is implemented as described.
- Undefined: RNG_SUM_DATA is tied to 0 and the adder is removed; all other behaviour is unchanged.

Decomposition:
- Shared package rng_pkg holds:
  - state enum rng_state_t {IDLE, RUN, FLUSH, DRAIN};
  - constant RNG_WORD_BYTES = 4;
  - constant RNG_BYTE_MASK = ~3.
- One sub-module, rng_out_slot: a single-entry output register with load, accept and full flag that drives TDATA/TVALID/TLAST.
- The FSM and counters stay in the top module.

Test Plan:
- Bounded run: SEND=16, DMA=8, RND_VALID every cycle, TREADY=1 -> 4 words, TLAST on words 2 and 4, SENT_BYTES=16, RUN falls 1 cycle after the last handshake, OVER=0.
- Budget rounding: SEND=10 -> BUD=8; DMA=0 -> PL=4 -> 2 words each with TLAST, SENT_BYTES=8.
- Backpressure: RND_VALID every cycle, TREADY low 3 cycles after the first word -> TDATA held, OVER=1, OVER stays 1 after the run and clears on the next GO.
- Stop mid-packet:
  - SEND=0, DMA=16, STOP after 2 words handshaken -> FLUSH, exactly 1 more word with TLAST, then IDLE, SENT_BYTES=12.
  - STOP after exactly 4 words -> IDLE with no extra word.
- Reset mid-run: ARESET asserted while TVALID=1 -> TVALID, RUN, counters 0 immediately (async); a following GO starts clean.
- RNG_SUM_EN: words 0xFFFFFFFF and 0x00000002 -> SUM_DATA=0x00000001. With the macro undefined, SUM_DATA=0.
